// File: rtl/traffic_pkg.sv
// Shared types and constants for the highway/farm-road intersection sequencer.
// Build option: define AMB_PREEMPT_EN to enable ambulance preemption (EMG phase).
package traffic_pkg;

  localparam int PHASE_W = 3;
  localparam int CNT_W   = 32;

  typedef enum logic [PHASE_W-1:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    FG  = 3'd3,
    FY  = 3'd4,
    AR2 = 3'd5,
    EMG = 3'd6
  } phase_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef struct packed {
    logic [2:0] hwy;
    logic [2:0] farm;
  } lamps_t;

  // Yellow phases may only be left once their full duration has elapsed.
  function automatic logic is_yellow(input phase_t p);
    return (p == HY) || (p == FY);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating phase counter: cleared on every phase change, sticks at all-ones.
module phase_timer
  import traffic_pkg::*;
(
  input  logic             Clk,
  input  logic             reset,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge Clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (~&cnt) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/traffic_ctrl.sv
// Highway/farm-road phase sequencer with Moore lamp decode.
// Build option: AMB_PREEMPT_EN enables ambulance preemption into the EMG all-red hold.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int T_HG_MIN = 16,
  parameter int T_FG_MIN = 4,
  parameter int T_FG_MAX = 12,
  parameter int T_Y      = 4,
  parameter int T_AR     = 2
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               C,
  input  logic               AMB,
  output logic [2:0]         HWY_LIGHT,
  output logic [2:0]         FARM_LIGHT,
  output logic [PHASE_W-1:0] PHASE,
  output logic               PREEMPT
);

  localparam logic [CNT_W-1:0] HG_LAST     = CNT_W'(T_HG_MIN - 1);
  localparam logic [CNT_W-1:0] FG_MIN_LAST = CNT_W'(T_FG_MIN - 1);
  localparam logic [CNT_W-1:0] FG_MAX_LAST = CNT_W'(T_FG_MAX - 1);
  localparam logic [CNT_W-1:0] Y_LAST      = CNT_W'(T_Y - 1);
  localparam logic [CNT_W-1:0] AR_LAST     = CNT_W'(T_AR - 1);

  phase_t           state;
  phase_t           next_state;
  logic             state_change;
  logic [CNT_W-1:0] cnt;
  logic             amb_req;
  logic             y_done;
  lamps_t           lamps;

`ifdef AMB_PREEMPT_EN
  assign amb_req = AMB;
`else
  assign amb_req = AMB & 1'b0;
`endif

  assign state_change = (next_state != state);
  assign y_done       = is_yellow(state) && (cnt == Y_LAST);

  phase_timer u_timer (
    .Clk   (Clk),
    .reset (reset),
    .clear (state_change),
    .cnt   (cnt)
  );

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state <= HG;
    end else begin
      state <= next_state;
    end
  end

  // First matching rule wins in every phase; an ambulance only redirects a yellow's exit.
  always_comb begin
    next_state = state;
    case (state)
      HG: begin
        if (amb_req) begin
          next_state = HY;
        end else if (C && (cnt >= HG_LAST)) begin
          next_state = HY;
        end
      end
      HY: begin
        if (y_done) begin
          next_state = amb_req ? EMG : AR1;
        end
      end
      AR1: begin
        if (amb_req) begin
          next_state = EMG;
        end else if (cnt == AR_LAST) begin
          next_state = FG;
        end
      end
      FG: begin
        if (amb_req) begin
          next_state = FY;
        end else if (cnt == FG_MAX_LAST) begin
          next_state = FY;
        end else if (!C && (cnt >= FG_MIN_LAST)) begin
          next_state = FY;
        end
      end
      FY: begin
        if (y_done) begin
          next_state = amb_req ? EMG : AR2;
        end
      end
      AR2: begin
        if (amb_req) begin
          next_state = EMG;
        end else if (cnt == AR_LAST) begin
          next_state = HG;
        end
      end
      EMG: begin
`ifdef AMB_PREEMPT_EN
        next_state = amb_req ? EMG : AR2;
`else
        next_state = HG;
`endif
      end
      default: begin
        next_state = HG;
      end
    endcase
  end

  always_comb begin
    lamps = '{hwy: LAMP_R, farm: LAMP_R};
    case (state)
      HG:      lamps = '{hwy: LAMP_G, farm: LAMP_R};
      HY:      lamps = '{hwy: LAMP_Y, farm: LAMP_R};
      FG:      lamps = '{hwy: LAMP_R, farm: LAMP_G};
      FY:      lamps = '{hwy: LAMP_R, farm: LAMP_Y};
      default: lamps = '{hwy: LAMP_R, farm: LAMP_R};
    endcase
  end

  assign HWY_LIGHT  = lamps.hwy;
  assign FARM_LIGHT = lamps.farm;
  assign PHASE      = state;

`ifdef AMB_PREEMPT_EN
  assign PREEMPT = (state == EMG);
`else
  assign PREEMPT = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_ctrl.sv
// Self-checking bench for traffic_ctrl: directed phase-timing scenarios plus random C/AMB/reset
// traffic checked cycle by cycle against a rule-level model. Follows AMB_PREEMPT_EN like the RTL.
module tb_traffic_ctrl;

  localparam int T_HG_MIN = 16;
  localparam int T_FG_MIN = 4;
  localparam int T_FG_MAX = 12;
  localparam int T_Y      = 4;
  localparam int T_AR     = 2;

  localparam int P_HG = 0, P_HY = 1, P_AR1 = 2, P_FG = 3, P_FY = 4, P_AR2 = 5, P_EMG = 6;

`ifdef AMB_PREEMPT_EN
  localparam bit AMB_ON = 1'b1;
`else
  localparam bit AMB_ON = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       reset;
  logic       C;
  logic       AMB;
  logic [2:0] HWY_LIGHT;
  logic [2:0] FARM_LIGHT;
  logic [2:0] PHASE;
  logic       PREEMPT;

  int total = 0;
  int bad   = 0;
  int m_phase = P_HG;
  int m_time  = 0;

  traffic_ctrl #(
    .T_HG_MIN (T_HG_MIN),
    .T_FG_MIN (T_FG_MIN),
    .T_FG_MAX (T_FG_MAX),
    .T_Y      (T_Y),
    .T_AR     (T_AR)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .C          (C),
    .AMB        (AMB),
    .HWY_LIGHT  (HWY_LIGHT),
    .FARM_LIGHT (FARM_LIGHT),
    .PHASE      (PHASE),
    .PREEMPT    (PREEMPT)
  );

  initial forever #5 Clk = ~Clk;

  // Rule table in terms of "cycles already spent in this phase, including this one".
  function automatic int model_next(input int p, input int t, input bit c, input bit amb);
    int spent;
    spent = t + 1;
    case (p)
      P_HG:  return (amb || (c && spent >= T_HG_MIN)) ? P_HY : P_HG;
      P_HY:  return (spent == T_Y) ? (amb ? P_EMG : P_AR1) : P_HY;
      P_AR1: return amb ? P_EMG : ((spent == T_AR) ? P_FG : P_AR1);
      P_FG:  return (amb || spent == T_FG_MAX || (!c && spent >= T_FG_MIN)) ? P_FY : P_FG;
      P_FY:  return (spent == T_Y) ? (amb ? P_EMG : P_AR2) : P_FY;
      P_AR2: return amb ? P_EMG : ((spent == T_AR) ? P_HG : P_AR2);
      P_EMG: return amb ? P_EMG : P_AR2;
      default: return P_HG;
    endcase
  endfunction

  function automatic logic [2:0] exp_hwy(input int p);
    if (p == P_HG) return 3'b001;
    if (p == P_HY) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] exp_farm(input int p);
    if (p == P_FG) return 3'b001;
    if (p == P_FY) return 3'b010;
    return 3'b100;
  endfunction

  task automatic model_step();
    int nxt;
    if (!reset) begin
      m_phase = P_HG;
      m_time  = 0;
    end else begin
      nxt = model_next(m_phase, m_time, C, AMB && AMB_ON);
      if (nxt != m_phase) begin
        m_phase = nxt;
        m_time  = 0;
      end else begin
        m_time++;
      end
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    total++;
    assert (HWY_LIGHT === exp_hwy(m_phase)) else begin
      bad++;
      $error("[TB] FAIL hwy_light observed=%b expected=%b", HWY_LIGHT, exp_hwy(m_phase));
    end
    total++;
    assert (FARM_LIGHT === exp_farm(m_phase)) else begin
      bad++;
      $error("[TB] FAIL farm_light observed=%b expected=%b", FARM_LIGHT, exp_farm(m_phase));
    end
    total++;
    assert (PHASE === 3'(m_phase)) else begin
      bad++;
      $error("[TB] FAIL phase observed=%0d expected=%0d", PHASE, m_phase);
    end
    total++;
    assert (PREEMPT === (AMB_ON && m_phase == P_EMG)) else begin
      bad++;
      $error("[TB] FAIL preempt observed=%b expected=%b", PREEMPT, (AMB_ON && m_phase == P_EMG));
    end
  endtask

  // Inputs change at the falling edge; the model follows the rising edge; outputs are checked at the next fall.
  task automatic applyStimulus(input logic c, input logic amb);
    C   = c;
    AMB = amb;
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    checkOutput();
  endtask

  task automatic measure_run(input int ph, input logic c, input logic amb, output int len);
    len = 0;
    while (int'(PHASE) == ph && len < 300) begin
      len++;
      applyStimulus(c, amb);
    end
  endtask

  task automatic advance_to(input int ph, input logic c, input logic amb);
    int n;
    n = 0;
    while (int'(PHASE) != ph && n < 300) begin
      applyStimulus(c, amb);
      n++;
    end
    check_int($sformatf("advance_to_%0d", ph), int'(PHASE), ph);
  endtask

  initial begin
    int len;
    int hg_ok;
    bit rc;
    bit ra;

    reset = 1'b0;
    C     = 1'b0;
    AMB   = 1'b0;
    $display("[TB] reset");
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    reset = 1'b1;
    check_int("reset_cnt", int'(dut.cnt), 0);
    check_int("reset_phase", int'(PHASE), P_HG);

    $display("[TB] idle");
    hg_ok = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1'b0);
      if (HWY_LIGHT === 3'b001 && FARM_LIGHT === 3'b100) hg_ok++;
    end
    check_int("idle_hg_cycles", hg_ok, 100);

    $display("[TB] early demand");
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0);
    reset = 1'b1;
    measure_run(P_HG, 1'b1, 1'b0, len);  check_int("hg_len", len, T_HG_MIN);
    measure_run(P_HY, 1'b1, 1'b0, len);  check_int("hy_len", len, T_Y);
    measure_run(P_AR1, 1'b1, 1'b0, len); check_int("ar1_len", len, T_AR);
    measure_run(P_FG, 1'b1, 1'b0, len);  check_int("fg_max_len", len, T_FG_MAX);
    measure_run(P_FY, 1'b1, 1'b0, len);  check_int("fy_len", len, T_Y);
    measure_run(P_AR2, 1'b1, 1'b0, len); check_int("ar2_len", len, T_AR);
    check_int("back_to_hg", int'(PHASE), P_HG);

    $display("[TB] short farm visit");
    advance_to(P_FG, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    measure_run(P_FG, 1'b0, 1'b0, len);
    check_int("fg_min_len", len + 1, T_FG_MIN);
    advance_to(P_HG, 1'b0, 1'b0);
    advance_to(P_FG, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    check_int("fg_drop_late", int'(PHASE), P_FY);
    advance_to(P_HG, 1'b0, 1'b0);

    $display("[TB] preemption");
    advance_to(P_FG, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
`ifdef AMB_PREEMPT_EN
    measure_run(P_FG, 1'b1, 1'b1, len);  check_int("fg_amb_exit", len, 1);
    measure_run(P_FY, 1'b1, 1'b1, len);  check_int("fy_amb_len", len, T_Y);
    check_int("emg_entered", int'(PHASE), P_EMG);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1);
    check_int("emg_preempt", int'(PREEMPT), 1);
    measure_run(P_EMG, 1'b0, 1'b0, len); check_int("emg_release", len, 1);
    measure_run(P_AR2, 1'b0, 1'b0, len); check_int("ar2_after_emg", len, T_AR);
    check_int("hg_after_emg", int'(PHASE), P_HG);
`else
    measure_run(P_FG, 1'b1, 1'b1, len);  check_int("fg_amb_ignored", len, T_FG_MAX - 2);
    check_int("preempt_tied", int'(PREEMPT), 0);
    advance_to(P_HG, 1'b0, 1'b1);
`endif

    $display("[TB] preempt during yellow");
    advance_to(P_HY, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    measure_run(P_HY, 1'b0, 1'b0, len);
    check_int("hy_not_shortened", len + 3, T_Y);
    check_int("hy_exit_ar1", int'(PHASE), P_AR1);

    $display("[TB] reset mid-phase");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1);
    reset = 1'b1;
    check_int("midreset_phase", int'(PHASE), P_HG);
    check_int("midreset_preempt", int'(PREEMPT), 0);
    check_int("midreset_cnt", int'(dut.cnt), 0);

    $display("[TB] random traffic");
    rc = 1'b0;
    ra = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rc = ~rc;
      if ($urandom_range(0, 29) == 0) ra = ~ra;
      reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      applyStimulus(rc, ra);
    end
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
